instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Parametrised successor to the single-word combinational instruction decoder. It buffers incoming instruction words in a FIFO, issues each one for one or more cycles under a per-instruction repeat count, and drives registered, decoded control strobes and fields to the systolic array, bias/activation datapath and weight FIFO. Stall and flush inputs let the host pause or abort issue without losing buffered words.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high.

Parameters:
- `DATA_W`, 16: width of the immediate data field.
- `ADDR_W`, 1: width of the address field.
- `REP_W`, 4: width of the repeat field.
- `DEPTH`, 8: FIFO entries, power of two, at least 2.
- `INSTR_W`, `REP_W+8+ADDR_W+DATA_W`: derived, not overridable.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `instr_in`, in, INSTR_W: instruction word.
- `instr_valid`, in, 1: host offers `instr_in`.
- `instr_ready`, out, 1: equals `!full && !flush`.
- `stall`, in, 1: freeze issue.
- `flush`, in, 1: empty FIFO and abort the current instruction.
- `out_valid`, out, 1: the outputs carry a live issue cycle.
- `nn_start`, `accept_w`, `switch`, `load_weights`, `load_bias`, `load_inputs`, out, 1 each: strobes.
- `activation_datapath`, out, 2: activation routing.
- `lr_is_backward`, out, 1: backward-pass mode.
- `address`, out, ADDR_W: address field.
- `data_in`, out, DATA_W: immediate data.
- `busy`, out, 1: state is ISSUE.
- `empty`, `full`, out, 1 each: FIFO status.
- `count`, out, $clog2(DEPTH+1): FIFO occupancy.

## Operation
Instruction layout, LSB first:
- data `[DATA_W-1:0]`
- address `[+ADDR_W]`
- load_sel `[2]`
- activation_datapath `[2]`
- switch, accept_w, nn_start, lr_is_backward `[1 each]`
- repeat `[REP_W]`, at the MSB

With default parameters the low 25 bits keep the legacy layout, and repeat occupies `[28:25]`.

load_sel decode:
- 00: no load.
- 01: `load_inputs`.
- 10: `load_weights`.
- 11: `load_bias`.

Exactly one load strobe is active, or none.

Write side: an instruction is pushed when `instr_valid && instr_ready`. A push is refused while full, even if a pop happens in the same cycle.

Issue FSM:
- IDLE: if FIFO is non-empty and `!stall`, pop the head, register the decoded fields, load `rep_cnt` with the word's repeat value, and go to ISSUE.
- ISSUE: each non-stalled cycle is one issue cycle.
  - If `rep_cnt != 0`, decrement it and reissue the same word.
  - If `rep_cnt == 0` and the FIFO is non-empty, pop the next word (stay in ISSUE).
  - Otherwise go to IDLE.
- Each word is therefore issued repeat+1 times.

Output rules:
- `out_valid` is high on every issue cycle.
- While `out_valid = 0`, all strobes (nn_start, accept_w, switch, the three loads) are 0.
- Level fields (`activation_datapath`, `lr_is_backward`, `address`, `data_in`) hold their last issued value.

Stall:
- `out_valid` and all strobes are 0, `rep_cnt` is frozen, and no pop occurs.
- Pushes are still accepted.
- Issue resumes the cycle after stall falls, with the remaining repeat count.

Flush:
- Next cycle: FIFO is empty, state is IDLE, `rep_cnt = 0`, `out_valid` and strobes are 0.
- Any push in the flush cycle is dropped.
- Flush takes priority over stall.

Reset (synchronous; also applies mid-instruction):
- All outputs are 0, FIFO is empty (`count = 0`, `empty = 1`, `full = 0`), and the state is IDLE.
- `instr_ready` is 1 after reset.

Pointer and count rules:
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- `count` is updated by +1 on push, −1 on pop, and unchanged when both or neither occur.

## Timing
- Latency: a word accepted at edge k, with an empty FIFO, IDLE state and no stall, drives the outputs from edge k+1.
- Throughput: repeat-0 words issue one per cycle with no bubbles while the FIFO stays non-empty.
- A word with repeat = R occupies R+1 consecutive non-stalled cycles.
- All outputs are registered; there is no combinational path from `instr_in` to the outputs.
- `instr_ready`, `full`, `empty` and `count` reflect registered state, except that `instr_ready` is also gated combinationally by `flush`.

## Structure
- Package `tpu_ctrl_pkg` holds:
  - the `load_sel_e` enum (NONE, INPUTS, WEIGHTS, BIAS);
  - the `seq_state_e` enum (IDLE, ISSUE);
  - field-offset localparams as functions of the parameters.
- Sub-module `instr_fifo`: parametrised synchronous FIFO (WIDTH, DEPTH) with push, pop, flush, full, empty and count.
- `instr_sequencer` contains the FSM, repeat counter and decode registers.

## Test plan
- Reset, then push `0x0840001` (load_sel = 10, data = 1, repeat = 0):
  - `load_weights = 1` and `data_in = 0x0001` for exactly one cycle, at the edge after the push;
  - `out_valid` is high for that cycle only.
- Push a word with repeat = 3 and `nn_start = 1`: `nn_start` is high for 4 consecutive cycles, then `busy` falls.
- Push 8 words with stall high:
  - `full = 1`, `instr_ready = 0`, `count = 8`;
  - a ninth push is refused;
  - after stall is released, all 8 words issue back-to-back in order.
- Word with repeat = 5; assert stall for 2 cycles after its 2nd issue cycle: strobes are 0 during the stall and 4 further issue cycles follow.
- Flush during issue of a repeat = 7 word with 3 words queued, plus a simultaneous push:
  - next cycle: `count = 0`, `out_valid = 0`, `busy = 0`;
  - the pushed word is never issued.
- Assert reset mid-repeat: all outputs are 0 on the next cycle and the FIFO is empty.

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
// Shared types and field offsets for the TPU instruction sequencer.
// Offsets are relative to the control byte that sits above address/data.
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        INPUTS  = 2'b01,
        WEIGHTS = 2'b10,
        BIAS    = 2'b11
    } load_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic nn_start;
        logic accept_w;
        logic sw;
        logic ld_weights;
        logic ld_bias;
        logic ld_inputs;
    } strb_t;

    localparam int LD_OFF  = 0;
    localparam int ACT_OFF = 2;
    localparam int SW_OFF  = 4;
    localparam int ACC_OFF = 5;
    localparam int NN_OFF  = 6;
    localparam int BWD_OFF = 7;
    localparam int CTL_W   = 8;

    function automatic int ctl_lsb(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    function automatic int rep_lsb(input int data_w, input int addr_w);
        return data_w + addr_w + CTL_W;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two.
// A push is refused whenever full, regardless of a same-cycle pop.
module instr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
            if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Buffers instruction words and issues each one repeat+1 times as
// registered control strobes and level fields, with stall and flush.
module instr_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int ADDR_W  = 1,
    parameter  int REP_W   = 4,
    parameter  int DEPTH   = 8,
    localparam int INSTR_W = REP_W + 8 + ADDR_W + DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INSTR_W-1:0]         instr_in,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       out_valid,
    output logic                       nn_start,
    output logic                       accept_w,
    output logic                       switch,
    output logic                       load_weights,
    output logic                       load_bias,
    output logic                       load_inputs,
    output logic [1:0]                 activation_datapath,
    output logic                       lr_is_backward,
    output logic [ADDR_W-1:0]          address,
    output logic [DATA_W-1:0]          data_in,
    output logic                       busy,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CL = ctl_lsb(DATA_W, ADDR_W);
    localparam int RL = rep_lsb(DATA_W, ADDR_W);

    logic [INSTR_W-1:0] head;
    logic               push, pop;

    seq_state_e         state_q;
    logic [REP_W-1:0]   rep_cnt_q;
    strb_t              cur_strb_q;
    strb_t              out_strb_q;
    logic               out_valid_q;
    logic [1:0]         act_q;
    logic               bwd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;

    function automatic strb_t decode(input logic [INSTR_W-1:0] w);
        strb_t s;
        s          = '0;
        s.nn_start = w[CL+NN_OFF];
        s.accept_w = w[CL+ACC_OFF];
        s.sw       = w[CL+SW_OFF];
        unique case (load_sel_e'(w[CL+LD_OFF +: 2]))
            NONE:    ;
            INPUTS:  s.ld_inputs  = 1'b1;
            WEIGHTS: s.ld_weights = 1'b1;
            BIAS:    s.ld_bias    = 1'b1;
        endcase
        return s;
    endfunction

    assign instr_ready = !full && !flush;
    assign push        = instr_valid && instr_ready;

    // Only a word with no remaining repeats may be replaced by the head.
    assign pop = !flush && !stall && !empty
              && (state_q == IDLE || rep_cnt_q == '0);

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (instr_in),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rep_cnt_q   <= '0;
            cur_strb_q  <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
            act_q       <= '0;
            bwd_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            rep_cnt_q   <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (stall) begin
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (pop) begin
            state_q     <= ISSUE;
            rep_cnt_q   <= head[RL +: REP_W];
            cur_strb_q  <= decode(head);
            out_strb_q  <= decode(head);
            out_valid_q <= 1'b1;
            act_q       <= head[CL+ACT_OFF +: 2];
            bwd_q       <= head[CL+BWD_OFF];
            addr_q      <= head[DATA_W +: ADDR_W];
            data_q      <= head[DATA_W-1:0];
        end else if (state_q == ISSUE && rep_cnt_q != '0) begin
            rep_cnt_q   <= rep_cnt_q - 1'b1;
            out_strb_q  <= cur_strb_q;
            out_valid_q <= 1'b1;
        end else begin
            state_q     <= IDLE;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid           = out_valid_q;
    assign nn_start            = out_strb_q.nn_start;
    assign accept_w            = out_strb_q.accept_w;
    assign switch              = out_strb_q.sw;
    assign load_weights        = out_strb_q.ld_weights;
    assign load_bias           = out_strb_q.ld_bias;
    assign load_inputs         = out_strb_q.ld_inputs;
    assign activation_datapath = act_q;
    assign lr_is_backward      = bwd_q;
    assign address             = addr_q;
    assign data_in             = data_q;
    assign busy                = (state_q == ISSUE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: queued issue records plus
// directed cycle-exact checks of latency, stall, flush and reset.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [28:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        nn_start, accept_w, switch_s;
    logic        load_weights, load_bias, load_inputs;
    logic [1:0]  activation_datapath;
    logic        lr_is_backward;
    logic [0:0]  address;
    logic [15:0] data_in;
    logic        busy, empty, full;
    logic [3:0]  count;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_in            (instr_in),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .stall               (stall),
        .flush               (flush),
        .out_valid           (out_valid),
        .nn_start            (nn_start),
        .accept_w            (accept_w),
        .switch              (switch_s),
        .load_weights        (load_weights),
        .load_bias           (load_bias),
        .load_inputs         (load_inputs),
        .activation_datapath (activation_datapath),
        .lr_is_backward      (lr_is_backward),
        .address             (address),
        .data_in             (data_in),
        .busy                (busy),
        .empty               (empty),
        .full                (full),
        .count               (count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent decode using the fixed default-parameter bit layout.
    function automatic logic [31:0] exp_of(input logic [28:0] w);
        logic [1:0] sel;
        sel = w[18:17];
        return 32'({w[23], w[22], w[21], sel == 2'b10, sel == 2'b11,
                    sel == 2'b01, w[20:19], w[24], w[16], w[15:0]});
    endfunction

    function automatic logic [28:0] mk(input int rep, input bit bwd,
        input bit nn, input bit acc, input bit sw, input int act,
        input int sel, input bit adr, input int dat);
        logic [28:0] w;
        w        = '0;
        w[28:25] = 4'(rep);
        w[24]    = bwd;
        w[23]    = nn;
        w[22]    = acc;
        w[21]    = sw;
        w[20:19] = 2'(act);
        w[18:17] = 2'(sel);
        w[16]    = adr;
        w[15:0]  = 16'(dat);
        return w;
    endfunction

    wire [31:0] got_w = 32'({nn_start, accept_w, switch_s, load_weights,
                             load_bias, load_inputs, activation_datapath,
                             lr_is_backward, address, data_in});
    wire [5:0]  strb_w = {nn_start, accept_w, switch_s, load_weights,
                          load_bias, load_inputs};

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) chk("sb_unexpected", 32'(out_valid), 32'd0);
            else chk("sb_issue", got_w, exp_q.pop_front());
        end else begin
            chk("idle_strobes", 32'(strb_w), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [28:0] w, input bit accept);
        instr_in    = w;
        instr_valid = 1'b1;
        if (accept)
            for (int r = 0; r <= int'(w[28:25]); r++) exp_q.push_back(exp_of(w));
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [28:0] w;
        rst = 1'b1; instr_in = '0; instr_valid = 1'b0;
        stall = 1'b0; flush = 1'b0;
        repeat (2) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_fields", got_w, 32'd0);
        rst = 1'b0;
        step();

        // Single repeat-0 load_weights word: one issue cycle, edge after push.
        push_word(29'h0840001, 1'b1);
        chk("t1_pre_valid", 32'(out_valid), 32'd0);
        chk("t1_pre_count", 32'(count), 32'd1);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_ldw", 32'(load_weights), 32'd1);
        chk("t1_data", 32'(data_in), 32'h0001);
        step();
        chk("t1_valid_off", 32'(out_valid), 32'd0);
        chk("t1_ldw_off", 32'(load_weights), 32'd0);
        chk("t1_data_hold", 32'(data_in), 32'h0001);
        chk("t1_busy_off", 32'(busy), 32'd0);

        // Repeat 3: nn_start for four consecutive cycles.
        push_word(mk(3, 0, 1, 0, 0, 1, 0, 1, 16'h1234), 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_nn", 32'(nn_start), 32'd1);
            chk("t2_busy", 32'(busy), 32'd1);
        end
        step();
        chk("t2_nn_off", 32'(nn_start), 32'd0);
        chk("t2_busy_off", 32'(busy), 32'd0);
        chk("t2_drain", 32'(exp_q.size()), 32'd0);

        // Fill under stall, refuse a ninth push, then drain back-to-back.
        stall = 1'b1;
        for (int i = 0; i < 8; i++)
            push_word(mk(0, i[0], i[2], i[1], i[0], i % 4, (i + 1) % 4,
                         i[1], 16'hA000 + i), 1'b1);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_ready", 32'(instr_ready), 32'd0);
        chk("t3_count", 32'(count), 32'd8);
        push_word(mk(0, 1, 1, 1, 1, 3, 3, 1, 16'hDEAD), 1'b0);
        chk("t3_count9", 32'(count), 32'd8);
        chk("t3_stalled", 32'(out_valid), 32'd0);
        stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_b2b", 32'(out_valid), 32'd1);
        end
        step();
        chk("t3_end", 32'(out_valid), 32'd0);
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_drain", 32'(exp_q.size()), 32'd0);

        // Repeat 5 with a 2-cycle stall after its second issue cycle.
        push_word(mk(5, 0, 0, 0, 1, 2, 1, 0, 16'h0055), 1'b1);
        step();
        chk("t4_issue1", 32'(load_inputs), 32'd1);
        step();
        chk("t4_issue2", 32'(switch_s), 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_stall_valid", 32'(out_valid), 32'd0);
            chk("t4_stall_strb", 32'(strb_w), 32'd0);
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_resume", 32'(out_valid), 32'd1);
        end
        step();
        chk("t4_done", 32'(out_valid), 32'd0);
        chk("t4_drain", 32'(exp_q.size()), 32'd0);

        // Flush while a repeat-7 word issues with three words queued.
        push_word(mk(7, 1, 1, 0, 0, 1, 3, 1, 16'h7777), 1'b1);
        step();
        for (int i = 0; i < 3; i++)
            push_word(mk(0, 0, 0, 1, 0, 0, 2, 0, 16'hB000 + i), 1'b1);
        chk("t5_count_pre", 32'(count), 32'd3);
        w = mk(0, 0, 1, 1, 1, 2, 2, 1, 16'hF00D);
        instr_in = w; instr_valid = 1'b1; flush = 1'b1;
        #1;
        chk("t5_ready_flush", 32'(instr_ready), 32'd0);
        step();
        flush = 1'b0; instr_valid = 1'b0;
        exp_q.delete();
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_issue", 32'(out_valid), 32'd0);
        end

        // Reset in the middle of a repeat.
        push_word(mk(7, 1, 1, 1, 1, 3, 3, 1, 16'hCAFE), 1'b1);
        push_word(mk(0, 0, 0, 0, 0, 0, 1, 0, 16'h0BAD), 1'b1);
        step();
        rst = 1'b1;
        step();
        exp_q.delete();
        chk("t6_fields", got_w, 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_full", 32'(full), 32'd0);
        rst = 1'b0;
        step();
        chk("t6_ready", 32'(instr_ready), 32'd1);
        step();
        chk("t6_idle", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
